gpio_irq_ctrl: RTL

GPIO input-conditioning and interrupt controller that sits directly upstream of the 9-bit Wishbone GPIO block. It consumes the raw pad inputs and the GPIO direction vector. Its processing chain is: synchronise each input, debounce it, detect rising/falling edges, latch pending interrupts and drive a single irq line to the CPU. Software accesses it as its own 32-bit Wishbone slave and can read the clean, filtered input vector.

---
 rtl/gpio_irq_ctrl_pkg.sv | 15 +
 rtl/gpio_debounce.sv | 48 ++++
 rtl/gpio_irq_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/gpio_irq_ctrl_pkg.sv
// Shared constants for the GPIO interrupt controller: Wishbone register offsets
// as selected by wb_adr_i[4:2].
package gpio_irq_ctrl_pkg;

  localparam int unsigned REG_SEL_W = 3;

  localparam logic [REG_SEL_W-1:0] REG_RAW  = 3'd0;
  localparam logic [REG_SEL_W-1:0] REG_FILT = 3'd1;
  localparam logic [REG_SEL_W-1:0] REG_EN   = 3'd2;
  localparam logic [REG_SEL_W-1:0] REG_RISE = 3'd3;
  localparam logic [REG_SEL_W-1:0] REG_FALL = 3'd4;
  localparam logic [REG_SEL_W-1:0] REG_PEND = 3'd5;
  localparam logic [REG_SEL_W-1:0] REG_DBP  = 3'd6;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin input conditioner: synchroniser chain followed by a counter-based
// debouncer whose period is shared across all pins.
module gpio_debounce #(
  parameter int unsigned DB_CNT_W    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pad_i,
  input  logic [DB_CNT_W-1:0] dbp_i,
  output logic                raw_o,
  output logic                filt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_CNT_W-1:0]    cnt_q;
  logic                   filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign raw_o = sync_q[SYNC_STAGES-1];

  // Equality compare: lowering dbp_i below a running count lets the count wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (raw_o != filt_q) begin
      if (cnt_q == dbp_i) begin
        filt_q <= raw_o;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + DB_CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO input conditioning and edge-interrupt controller with a 32-bit Wishbone
// slave for configuration, status and W1C pending clear.
module gpio_irq_ctrl
  import gpio_irq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned DB_CNT_W    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WB_DAT_W    = 32,
  parameter int unsigned WB_ADR_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WB_ADR_W-1:0] wb_adr_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic                wb_ack_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic [WIDTH-1:0]    gpio_i,
  input  logic [WIDTH-1:0]    gpio_dir_i,
  output logic [WIDTH-1:0]    gpio_filt_o,
  output logic                irq_o
);

  logic [WIDTH-1:0]     raw;
  logic [WIDTH-1:0]     filt;
  logic [WIDTH-1:0]     filt_d_q;
  logic [WIDTH-1:0]     en_q, rise_q, fall_q, pend_q;
  logic [DB_CNT_W-1:0]  dbp_q;
  logic                 ack_q;
  logic                 irq_q;
  logic [WB_DAT_W-1:0]  dat_q;
  logic [WB_DAT_W-1:0]  rd_data;
  logic [REG_SEL_W-1:0] reg_sel;
  logic                 acc;
  logic                 wr;
  logic [WIDTH-1:0]     pend_clr;
  logic [WIDTH-1:0]     rise, fall, hit;
  logic                 unused_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(
      .DB_CNT_W   (DB_CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .pad_i (gpio_i[i]),
      .dbp_i (dbp_q),
      .raw_o (raw[i]),
      .filt_o(filt[i])
    );
  end

  assign reg_sel  = wb_adr_i[4:2];
  assign acc      = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr       = acc & wb_we_i;
  assign pend_clr = (wr && reg_sel == REG_PEND) ? wb_dat_i[WIDTH-1:0] : '0;

  assign rise = filt & ~filt_d_q;
  assign fall = ~filt & filt_d_q;
  assign hit  = ((rise & rise_q) | (fall & fall_q)) & ~gpio_dir_i & en_q;

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_RAW:  rd_data[WIDTH-1:0]    = raw;
      REG_FILT: rd_data[WIDTH-1:0]    = filt;
      REG_EN:   rd_data[WIDTH-1:0]    = en_q;
      REG_RISE: rd_data[WIDTH-1:0]    = rise_q;
      REG_FALL: rd_data[WIDTH-1:0]    = fall_q;
      REG_PEND: rd_data[WIDTH-1:0]    = pend_q;
      REG_DBP:  rd_data[DB_CNT_W-1:0] = dbp_q;
      default:  rd_data               = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      en_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
      dbp_q    <= '0;
      filt_d_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      ack_q <= acc;
      if (acc && !wb_we_i) begin
        dat_q <= rd_data;
      end
      if (wr) begin
        case (reg_sel)
          REG_EN:   en_q   <= wb_dat_i[WIDTH-1:0];
          REG_RISE: rise_q <= wb_dat_i[WIDTH-1:0];
          REG_FALL: fall_q <= wb_dat_i[WIDTH-1:0];
          REG_DBP:  dbp_q  <= wb_dat_i[DB_CNT_W-1:0];
          default:  ;
        endcase
      end
      filt_d_q <= filt;
      // A new hit overrides a simultaneous W1C of the same bit.
      pend_q   <= (pend_q & ~pend_clr) | hit;
      irq_q    <= |(pend_q & en_q);
    end
  end

  assign wb_ack_o    = wb_stb_i & wb_cyc_i & ack_q;
  assign wb_dat_o    = dat_q;
  assign gpio_filt_o = filt;
  assign irq_o       = irq_q;

  assign unused_bits = ^{wb_adr_i[WB_ADR_W-1:5], wb_adr_i[1:0], wb_dat_i[WB_DAT_W-1:DB_CNT_W]};

endmodule
